instr_sequencer: RTL and testbench

//  Central control unit for the 16-bit microcontroller. Sequences the fetch over the shared bus:
//  PC->MAR, memory read, MDR->IR. Decodes the execution class, starts exactly one execution FSM
//  (ALU, ALUI, LOAD/STORE, MOV, MOVI), waits for its done, then advances the PC.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/bus_contention_mon.sv | 27 ++
 rtl/instr_sequencer.sv | 163 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, class codes, exec
// indices and error codes.
package cpu_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFPc,
    StFMem,
    StFLat,
    StFIr,
    StDecode,
    StStart,
    StExec,
    StAdv,
    StError
  } seq_state_e;

  localparam int unsigned CLASS_MSB = 11;
  localparam int unsigned CLASS_LSB = 9;

  localparam logic [2:0] CLS_ALU  = 3'b000;
  localparam logic [2:0] CLS_ALUI = 3'b001;
  localparam logic [2:0] CLS_LS   = 3'b010;
  localparam logic [2:0] CLS_MOV  = 3'b011;
  localparam logic [2:0] CLS_MOVI = 3'b100;

  // Exec bus bit order is {MOVI, MOV, LS, ALUI, ALU}.
  localparam int unsigned N_EXEC        = 5;
  localparam int unsigned EXEC_IDX_ALU  = 0;
  localparam int unsigned EXEC_IDX_ALUI = 1;
  localparam int unsigned EXEC_IDX_LS   = 2;
  localparam int unsigned EXEC_IDX_MOV  = 3;
  localparam int unsigned EXEC_IDX_MOVI = 4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MFC     = 2'b01;
  localparam logic [1:0] ERR_EXEC    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  function automatic logic cls_legal(logic [2:0] cls);
    return cls <= CLS_MOVI;
  endfunction

  function automatic logic [2:0] cls_to_idx(logic [2:0] cls);
    logic [2:0] idx;
    unique case (cls)
      CLS_ALUI: idx = 3'(EXEC_IDX_ALUI);
      CLS_LS:   idx = 3'(EXEC_IDX_LS);
      CLS_MOV:  idx = 3'(EXEC_IDX_MOV);
      CLS_MOVI: idx = 3'(EXEC_IDX_MOVI);
      default:  idx = 3'(EXEC_IDX_ALU);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bus_contention_mon.sv
// Flags, sticky until reset, any cycle in which more than one bus driver is enabled.
module bus_contention_mon #(
  parameter int unsigned N_DRV = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_DRV-1:0] drv_en_i,
  output logic             conflict_o
);

  logic multi_drv;
  logic conflict_q;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_drv = |(drv_en_i & (drv_en_i - N_DRV'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_q <= 1'b0;
    end else if (multi_drv) begin
      conflict_q <= 1'b1;
    end
  end

  assign conflict_o = conflict_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: drives the fetch strobes on the shared bus, launches one
// execution FSM per instruction and advances the PC; timeouts park it in ERROR.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MFC_TIMEOUT  = 16,
  parameter int unsigned EXEC_TIMEOUT = 64,
  parameter int unsigned N_DRV        = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_req_i,
  input  logic              mfc_i,
  input  logic [15:0]       ir_i,
  input  logic [N_EXEC-1:0] exec_done_i,
  input  logic [N_DRV-1:0]  drv_en_i,
  output logic              pc_out_o,
  output logic              mar_en_o,
  output logic              mem_en_o,
  output logic              mem_rw_o,
  output logic              mdr_en_read_o,
  output logic              mdr_out_o,
  output logic              ir_en_o,
  output logic [N_EXEC-1:0] exec_start_o,
  output logic              pc_inc_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              bus_conflict_o
);

  // One counter serves both waits, so it is sized for the longer one (MFC_TIMEOUT <= EXEC_TIMEOUT).
  localparam int unsigned     CntW     = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CntW-1:0] MfcLast  = CntW'(MFC_TIMEOUT - 1);
  localparam logic [CntW-1:0] ExecLast = CntW'(EXEC_TIMEOUT - 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]      sel_q, sel_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [2:0]      cls;

  logic unused_ir;
  assign unused_ir = ^{ir_i[15:CLASS_MSB+1], ir_i[CLASS_LSB-1:0]};

  assign cls     = ir_i[CLASS_MSB:CLASS_LSB];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    err_code_d = err_code_q;
    case (state_q)
      StIdle: begin
        if (!halt_req_i) state_d = StFPc;
      end
      StFPc: begin
        cnt_d   = '0;
        state_d = StFMem;
      end
      StFMem: begin
        if (mfc_i) begin
          state_d = StFLat;
        end else if (cnt_q >= MfcLast) begin
          state_d    = StError;
          err_code_d = ERR_MFC;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StFLat: state_d = StFIr;
      StFIr:  state_d = StDecode;
      StDecode: begin
        if (cls_legal(cls)) begin
          sel_d   = cls_to_idx(cls);
          state_d = StStart;
        end else begin
          state_d    = StError;
          err_code_d = ERR_ILLEGAL;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StExec;
      end
      StExec: begin
        // Done is checked first so it wins over a simultaneous timeout.
        if (exec_done_i[sel_q]) begin
          state_d = StAdv;
        end else if (cnt_q >= ExecLast) begin
          state_d    = StError;
          err_code_d = ERR_EXEC;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StAdv:   state_d = halt_req_i ? StIdle : StFPc;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_out_o      = 1'b0;
    mar_en_o      = 1'b0;
    mem_en_o      = 1'b0;
    mem_rw_o      = 1'b0;
    mdr_en_read_o = 1'b0;
    mdr_out_o     = 1'b0;
    ir_en_o       = 1'b0;
    exec_start_o  = '0;
    pc_inc_o      = 1'b0;
    halted_o      = 1'b0;
    err_o         = 1'b0;
    case (state_q)
      StIdle:  halted_o = halt_req_i & ~rst_i;
      StFPc: begin
        pc_out_o = 1'b1;
        mar_en_o = 1'b1;
      end
      StFMem:  mem_en_o = 1'b1;
      StFLat: begin
        mem_en_o      = 1'b1;
        mdr_en_read_o = 1'b1;
      end
      StFIr: begin
        mdr_out_o = 1'b1;
        ir_en_o   = 1'b1;
      end
      StStart: exec_start_o = N_EXEC'(1) << sel_q;
      StAdv:   pc_inc_o = 1'b1;
      StError: err_o = 1'b1;
      default: ;
    endcase
  end

  assign err_code_o = err_code_q;

  bus_contention_mon #(
    .N_DRV(N_DRV)
  ) u_bus_mon (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .drv_en_i  (drv_en_i),
    .conflict_o(bus_conflict_o)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: expected exec_start values are queued when the
// instruction is presented and popped when the start pulse appears.
module tb_instr_sequencer;

  logic       clk, rst, halt_req, mfc;
  logic [15:0] ir;
  logic [4:0] exec_done;
  logic [9:0] drv_en;
  logic       pc_out, mar_en, mem_en, mem_rw, mdr_en_read, mdr_out, ir_en;
  logic [4:0] exec_start;
  logic       pc_inc, halted, err, bus_conflict;
  logic [1:0] err_code;

  logic [6:0]  fetch_v;
  logic [17:0] all_v;
  assign fetch_v = {pc_out, mar_en, mem_en, mem_rw, mdr_en_read, mdr_out, ir_en};
  assign all_v   = {fetch_v, exec_start, pc_inc, halted, err, err_code, bus_conflict};

  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;

  instr_sequencer #(
    .MFC_TIMEOUT (16),
    .EXEC_TIMEOUT(64),
    .N_DRV       (10)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .halt_req_i    (halt_req),
    .mfc_i         (mfc),
    .ir_i          (ir),
    .exec_done_i   (exec_done),
    .drv_en_i      (drv_en),
    .pc_out_o      (pc_out),
    .mar_en_o      (mar_en),
    .mem_en_o      (mem_en),
    .mem_rw_o      (mem_rw),
    .mdr_en_read_o (mdr_en_read),
    .mdr_out_o     (mdr_out),
    .ir_en_o       (ir_en),
    .exec_start_o  (exec_start),
    .pc_inc_o      (pc_inc),
    .halted_o      (halted),
    .err_o         (err),
    .err_code_o    (err_code),
    .bus_conflict_o(bus_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; halt_req = 1'b0; mfc = 1'b0; ir = '0; exec_done = '0; drv_en = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until a start pulse is seen; n = cycles taken, or -1 if the budget ran out.
  task automatic run_until_start(input int max, output int n);
    bit seen = 1'b0;
    n = -1;
    for (int i = 1; i <= max && !seen; i++) begin
      tick();
      if (exec_start != 5'b0) begin
        n = i;
        seen = 1'b1;
      end
    end
  endtask

  task automatic pop_compare(input string name);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got start %b with empty scoreboard", name, exec_start);
    end else begin
      exp_v = exp_q.pop_front();
      if (exec_start !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", name, exec_start, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt_req = 1'b0; mfc = 1'b1; ir = '0; exec_done = '1; drv_en = 10'b11;
    #3;
    n_cmp++;
    if (all_v !== 18'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b want %b", all_v, 18'b0);
    end
    apply_reset();
    n_cmp++;
    if (all_v !== 18'b0) begin
      n_fail++; $display("FAIL reset_idle_outs: got %b want %b", all_v, 18'b0);
    end
  endtask

  task automatic test_alu();
    apply_reset();
    ir = 16'h0000;
    exp_q.push_back(5'b00001);
    tick();
    n_cmp++;
    if (fetch_v !== 7'b1100000) begin
      n_fail++; $display("FAIL alu_fpc: got %b want %b", fetch_v, 7'b1100000);
    end
    mfc = 1'b1;
    tick();
    n_cmp++;
    if (fetch_v !== 7'b0010000) begin
      n_fail++; $display("FAIL alu_fmem: got %b want %b", fetch_v, 7'b0010000);
    end
    tick();
    mfc = 1'b0;
    n_cmp++;
    if (fetch_v !== 7'b0010100) begin
      n_fail++; $display("FAIL alu_flat: got %b want %b", fetch_v, 7'b0010100);
    end
    tick();
    n_cmp++;
    if (fetch_v !== 7'b0000011) begin
      n_fail++; $display("FAIL alu_fir: got %b want %b", fetch_v, 7'b0000011);
    end
    tick();
    n_cmp++;
    if ({fetch_v, exec_start} !== 12'b0) begin
      n_fail++; $display("FAIL alu_decode: got %b want %b", {fetch_v, exec_start}, 12'b0);
    end
    tick();
    pop_compare("alu_start");
    tick();
    n_cmp++;
    if (exec_start !== 5'b0) begin
      n_fail++; $display("FAIL alu_start_width: got %b want %b", exec_start, 5'b0);
    end
    tick();
    tick();
    exec_done = 5'b00001;
    tick();
    exec_done = 5'b0;
    n_cmp++;
    if (pc_inc !== 1'b1) begin
      n_fail++; $display("FAIL alu_pc_inc: got %b want %b", pc_inc, 1'b1);
    end
    tick();
    n_cmp++;
    if ({pc_out, pc_inc} !== 2'b10) begin
      n_fail++; $display("FAIL alu_next_fpc: got %b want %b", {pc_out, pc_inc}, 2'b10);
    end
  endtask

  task automatic test_movi_ignores_other_done();
    int n;
    apply_reset();
    ir = 16'h0800; mfc = 1'b1;
    exp_q.push_back(5'b10000);
    run_until_start(20, n);
    n_cmp++;
    if (n !== 6) begin
      n_fail++; $display("FAIL movi_start_latency: got %0d want %0d", n, 6);
    end
    pop_compare("movi_start");
    tick();
    exec_done = 5'b00010;
    tick();
    tick();
    exec_done = 5'b0;
    n_cmp++;
    if ({pc_inc, err} !== 2'b00) begin
      n_fail++; $display("FAIL movi_wrong_done: got %b want %b", {pc_inc, err}, 2'b00);
    end
    exec_done = 5'b10000;
    tick();
    exec_done = 5'b0;
    n_cmp++;
    if (pc_inc !== 1'b1) begin
      n_fail++; $display("FAIL movi_pc_inc: got %b want %b", pc_inc, 1'b1);
    end
  endtask

  task automatic test_mfc_timeout();
    apply_reset();
    mfc = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    n_cmp++;
    if ({mem_en, err} !== 2'b10) begin
      n_fail++; $display("FAIL mfc_before_timeout: got %b want %b", {mem_en, err}, 2'b10);
    end
    tick();
    n_cmp++;
    if ({err, err_code} !== 3'b101) begin
      n_fail++; $display("FAIL mfc_timeout_err: got %b want %b", {err, err_code}, 3'b101);
    end
    n_cmp++;
    if ({fetch_v, exec_start, pc_inc, halted} !== 14'b0) begin
      n_fail++;
      $display("FAIL mfc_timeout_strobes: got %b want %b",
               {fetch_v, exec_start, pc_inc, halted}, 14'b0);
    end
    mfc = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({err, err_code, fetch_v} !== 10'b1010000000) begin
      n_fail++; $display("FAIL mfc_err_sticky: got %b want %b", {err, err_code, fetch_v},
                         10'b1010000000);
    end
  endtask

  task automatic test_illegal_class();
    logic [4:0] starts = '0;
    apply_reset();
    ir = 16'h0A00; mfc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      starts |= exec_start;
    end
    n_cmp++;
    if ({err, err_code} !== 3'b111) begin
      n_fail++; $display("FAIL illegal_err: got %b want %b", {err, err_code}, 3'b111);
    end
    n_cmp++;
    if (starts !== 5'b0) begin
      n_fail++; $display("FAIL illegal_no_start: got %b want %b", starts, 5'b0);
    end
  endtask

  task automatic test_exec_timeout();
    int n;
    apply_reset();
    ir = 16'h0200; mfc = 1'b1;
    exp_q.push_back(5'b00010);
    run_until_start(20, n);
    pop_compare("alui_start");
    tick();
    for (int i = 0; i < 63; i++) tick();
    n_cmp++;
    if ({err, pc_inc} !== 2'b00) begin
      n_fail++; $display("FAIL exec_before_timeout: got %b want %b", {err, pc_inc}, 2'b00);
    end
    tick();
    n_cmp++;
    if ({err, err_code} !== 3'b110) begin
      n_fail++; $display("FAIL exec_timeout_err: got %b want %b", {err, err_code}, 3'b110);
    end
    // Done arriving in the final allowed cycle must still complete the instruction.
    apply_reset();
    ir = 16'h0200; mfc = 1'b1;
    exp_q.push_back(5'b00010);
    run_until_start(20, n);
    pop_compare("alui_start_2");
    tick();
    for (int i = 0; i < 63; i++) tick();
    exec_done = 5'b00010;
    tick();
    exec_done = 5'b0;
    n_cmp++;
    if ({pc_inc, err} !== 2'b10) begin
      n_fail++; $display("FAIL exec_done_wins: got %b want %b", {pc_inc, err}, 2'b10);
    end
  endtask

  task automatic test_halt();
    int n;
    apply_reset();
    ir = 16'h0600; mfc = 1'b1;
    exp_q.push_back(5'b01000);
    run_until_start(20, n);
    pop_compare("mov_start");
    tick();
    halt_req = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({halted, pc_inc} !== 2'b00) begin
      n_fail++; $display("FAIL halt_in_exec: got %b want %b", {halted, pc_inc}, 2'b00);
    end
    exec_done = 5'b01000;
    tick();
    exec_done = 5'b0;
    n_cmp++;
    if ({pc_inc, halted} !== 2'b10) begin
      n_fail++; $display("FAIL halt_adv: got %b want %b", {pc_inc, halted}, 2'b10);
    end
    tick();
    tick();
    n_cmp++;
    if ({halted, pc_out, pc_inc} !== 3'b100) begin
      n_fail++; $display("FAIL halt_idle: got %b want %b", {halted, pc_out, pc_inc}, 3'b100);
    end
    halt_req = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_release: got %b want %b", halted, 1'b0);
    end
    tick();
    n_cmp++;
    if (pc_out !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume_fpc: got %b want %b", pc_out, 1'b1);
    end
  endtask

  task automatic test_bus_conflict_and_reset();
    apply_reset();
    halt_req = 1'b1;
    drv_en = 10'b0000010000;
    tick();
    n_cmp++;
    if (bus_conflict !== 1'b0) begin
      n_fail++; $display("FAIL bus_single_drv: got %b want %b", bus_conflict, 1'b0);
    end
    drv_en = 10'b0000000101;
    #1;
    n_cmp++;
    if (bus_conflict !== 1'b0) begin
      n_fail++; $display("FAIL bus_not_yet: got %b want %b", bus_conflict, 1'b0);
    end
    tick();
    drv_en = 10'b0;
    n_cmp++;
    if (bus_conflict !== 1'b1) begin
      n_fail++; $display("FAIL bus_conflict_set: got %b want %b", bus_conflict, 1'b1);
    end
    halt_req = 1'b0; mfc = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus_conflict, mem_en} !== 2'b11) begin
      n_fail++; $display("FAIL bus_sticky_fmem: got %b want %b", {bus_conflict, mem_en}, 2'b11);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (all_v !== 18'b0) begin
      n_fail++; $display("FAIL async_reset: got %b want %b", all_v, 18'b0);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_movi_ignores_other_done();
    test_mfc_timeout();
    test_illegal_class();
    test_exec_timeout();
    test_halt();
    test_bus_conflict_and_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want %0d", exp_q.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
